// File: rtl/hex_display_formatter_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_formatter_if
// Purpose  : Bus between the debug-value source / LCD driver and the hex
//            display formatter. "force" is a SystemVerilog keyword, so the
//            re-render request is carried on force_req.
// Revision : 1.0 - initial release
// ============================================================================
interface hex_display_formatter_if #(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int NPAGE = 2
) ();
  localparam int PW = (NPAGE > 1) ? $clog2(NPAGE) : 1;

  logic [NCH*NPAGE*DW-1:0] ch_data;
  logic [PW-1:0]           page;
  logic                    force_req;
  logic                    disp_busy;
  logic [255:0]            strdata;
  logic                    cls;
  logic                    busy;

  // Environment side: supplies debug values and the driver's busy flag
  modport master (
    output ch_data, page, force_req, disp_busy,
    input  strdata, cls, busy
  );

  // Formatter side
  modport slave (
    input  ch_data, page, force_req, disp_busy,
    output strdata, cls, busy
  );
endinterface
`default_nettype wire

// File: rtl/hex_display_formatter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_formatter
// Purpose  : Renders the selected page of debug channels as uppercase ASCII
//            hex into a 32-char LCD buffer, one digit per cycle, then issues
//            a single-cycle refresh strobe honouring driver busy and a
//            minimum idle gap between strobes.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_formatter #(
  parameter int NCH     = 2,
  parameter int DW      = 32,
  parameter int NPAGE   = 2,
  parameter int MIN_GAP = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_display_formatter_if.slave bus
);

  localparam int DIGITS = DW / 4;
  localparam int PW     = (NPAGE > 1) ? $clog2(NPAGE) : 1;
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DGW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GW     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int NBW    = $clog2(DW);

  localparam logic [PW:0]    NPAGE_V  = (PW+1)'(NPAGE);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);
  localparam logic [DGW-1:0] DIG_LAST = DGW'(DIGITS - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(MIN_GAP - 1);

  // Reject configurations whose text cannot fit the 32-char buffer
  generate
    if ((DW % 4 != 0) || (DW < 4) || (NCH < 1) || (NPAGE < 1) || (MIN_GAP < 1) ||
        (NCH * (DIGITS + 1) - 1 > 32)) begin : g_bad_cfg
      $error("hex_display_formatter: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FORMAT   = 2'd1,
    WAIT_RDY = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   snap_val [NCH];
  logic [PW-1:0]   snap_page;
  logic            pending_force;
  logic [CHW-1:0]  ch_cnt;
  logic [DGW-1:0]  dig_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [255:0]    text_buf;
  logic            cls_pulse;

  logic [PW-1:0]   page_eff;
  logic [DW-1:0]   live_val [NCH];
  logic            mismatch;
  logic            start;
  logic            fmt_we;
  logic            cls_set;
  logic            last_digit;
  logic [7:0]      str_lsb;
  logic [NBW-1:0]  nib_lsb;
  logic [3:0]      nibble;
  logic [7:0]      ascii;

  // Out-of-range page selects fall back to page 0
  always_comb begin
    page_eff = ({1'b0, bus.page} < NPAGE_V) ? bus.page : '0;
  end

  // Live values of the shown page and comparison against the snapshot
  always_comb begin
    mismatch = (page_eff != snap_page);
    for (int k = 0; k < NCH; k++) begin
      live_val[k] = bus.ch_data[(int'(page_eff) * NCH + k) * DW +: DW];
      if (live_val[k] != snap_val[k]) mismatch = 1'b1;
    end
  end

  // Current digit position -> buffer slot, source nibble and its ASCII code
  always_comb begin
    str_lsb    = 8'(8 * (31 - (int'(ch_cnt) * (DIGITS + 1) + int'(dig_cnt))));
    nib_lsb    = NBW'(DW - 4 - 4 * int'(dig_cnt));
    nibble     = snap_val[ch_cnt][nib_lsb +: 4];
    ascii      = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    last_digit = (ch_cnt == CH_LAST) && (dig_cnt == DIG_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    fmt_we   = 1'b0;
    cls_set  = 1'b0;
    case (state)
      IDLE: begin
        if (mismatch || bus.force_req || pending_force) begin
          start    = 1'b1;
          state_nx = FORMAT;
        end
      end
      FORMAT: begin
        fmt_we = 1'b1;
        if (last_digit) state_nx = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (!bus.disp_busy) begin
          cls_set  = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Snapshot the rendered page when a render starts; inputs are ignored after
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_page <= '0;
      for (int k = 0; k < NCH; k++) snap_val[k] <= '0;
    end else if (start) begin
      snap_page <= page_eff;
      for (int k = 0; k < NCH; k++) snap_val[k] <= live_val[k];
    end
  end

  // Remember force requests seen while busy so exactly one render follows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               pending_force <= 1'b1;
    else if (start)         pending_force <= 1'b0;
    else if (bus.force_req) pending_force <= 1'b1;
  end

  // Digit walk: channel-major, MSB nibble first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt  <= '0;
      dig_cnt <= '0;
    end else if (start) begin
      ch_cnt  <= '0;
      dig_cnt <= '0;
    end else if (fmt_we) begin
      if (dig_cnt == DIG_LAST) begin
        dig_cnt <= '0;
        ch_cnt  <= ch_cnt + 1'b1;
      end else begin
        dig_cnt <= dig_cnt + 1'b1;
      end
    end
  end

  // Idle-gap counter, cleared whenever outside GAP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              gap_cnt <= '0;
    else if (state != GAP) gap_cnt <= '0;
    else                   gap_cnt <= gap_cnt + 1'b1;
  end

  // Text buffer: separators and unused slots keep the reset spaces
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        text_buf <= {32{8'h20}};
    else if (fmt_we) text_buf[str_lsb +: 8] <= ascii;
  end

  // Registered refresh strobe, high for one cycle on leaving WAIT_RDY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cls_pulse <= 1'b0;
    else      cls_pulse <= cls_set;
  end

  assign bus.strdata = text_buf;
  assign bus.cls     = cls_pulse;
  assign bus.busy    = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hex_display_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_formatter
// Purpose  : Directed self-checking bench for hex_display_formatter, with a
//            second NPAGE=3 instance for the out-of-range page mapping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_formatter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hex_display_formatter_if #(.NCH(2), .DW(32), .NPAGE(2)) bus ();
  hex_display_formatter_if #(.NCH(2), .DW(32), .NPAGE(3)) bus3 ();

  hex_display_formatter #(.NCH(2), .DW(32), .NPAGE(2), .MIN_GAP(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hex_display_formatter #(.NCH(2), .DW(32), .NPAGE(3), .MIN_GAP(16)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  localparam logic [255:0] SPACES = {32{8'h20}};

  int errors  = 0;
  int checks  = 0;
  int cls_cnt = 0;

  // Count strobes of the main instance, sampled shortly after each edge
  always @(posedge clk) begin
    #2;
    if (bus.cls === 1'b1) cls_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line17(input logic [135:0] s);
    return {s, {15{8'h20}}};
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Negedges until cls is seen, bounded
  task automatic wait_cls(input int budget, output int n);
    n = 0;
    while (bus.cls !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("cls_seen", {255'd0, bus.cls}, 256'd1);
  endtask

  task automatic idle_wait();
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", {255'd0, bus.busy}, 256'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int c0;

    bus.ch_data    = '0;
    bus.page       = '0;
    bus.force_req  = 1'b0;
    bus.disp_busy  = 1'b0;
    bus3.force_req = 1'b0;
    bus3.disp_busy = 1'b0;
    bus3.page      = 2'd3;
    bus3.ch_data   = {32'h44444444, 32'h33333333, 32'h22222222,
                      32'h11111111, 32'h12345678, 32'hCAFE0001};

    // Reset state
    cycles(3);
    check("rst_strdata", bus.strdata, SPACES);
    check("rst_cls", {255'd0, bus.cls}, 256'd0);
    check("rst_busy", {255'd0, bus.busy}, 256'd0);

    // Release: pending force renders zeros; change sampled at first edge t,
    // cls visible at the negedge after edge t+17 = 18 negedges later
    rst = 1'b1;
    wait_cls(40, n);
    check("rel_latency", 256'(n), 256'd18);
    check("rel_text", bus.strdata, line17("00000000 00000000"));
    check("page3_maps_p0", bus3.strdata, line17("CAFE0001 12345678"));
    cycles(15);
    check("gap_busy_hi", {255'd0, bus.busy}, 256'd1);
    cycles(1);
    check("gap_busy_lo", {255'd0, bus.busy}, 256'd0);
    check("rel_one_cls", 256'(cls_cnt), 256'd1);

    // Value change on ch0 page 0
    c0 = cls_cnt;
    bus.ch_data[31:0] = 32'h1234ABCD;
    wait_cls(40, n);
    check("chg_latency", 256'(n), 256'd18);
    check("chg_text", bus.strdata, line17("1234ABCD 00000000"));
    idle_wait();
    cycles(40);
    check("chg_one_cls", 256'(cls_cnt - c0), 256'd1);

    // Page switch with new page-1 values
    bus.page = 1'b1;
    bus.ch_data[95:64]  = 32'hDEADBEEF;
    bus.ch_data[127:96] = 32'h0000000F;
    wait_cls(40, n);
    check("page1_text", bus.strdata, line17("DEADBEEF 0000000F"));
    idle_wait();

    // Driver busy holds the strobe; force during GAP yields a second render
    c0 = cls_cnt;
    bus.disp_busy = 1'b1;
    bus.force_req = 1'b1;
    @(negedge clk);
    bus.force_req = 1'b0;
    cycles(67);
    check("held_no_cls", 256'(cls_cnt - c0), 256'd0);
    check("held_busy", {255'd0, bus.busy}, 256'd1);
    bus.disp_busy = 1'b0;
    @(negedge clk);
    check("rdy_cls", {255'd0, bus.cls}, 256'd1);
    cycles(3);
    bus.force_req = 1'b1;
    @(negedge clk);
    bus.force_req = 1'b0;
    wait_cls(80, n);
    check("force_text", bus.strdata, line17("DEADBEEF 0000000F"));
    check("force_two_cls", 256'(cls_cnt - c0), 256'd2);
    idle_wait();

    // Change during FORMAT: first render keeps old value, second shows new
    bus.page = 1'b0;
    cycles(5);
    bus.ch_data[31:0] = 32'h0BADF00D;
    wait_cls(40, n);
    check("mid_old_text", bus.strdata, line17("1234ABCD 00000000"));
    @(negedge clk);
    wait_cls(80, n);
    check("mid_new_text", bus.strdata, line17("0BADF00D 00000000"));
    idle_wait();

    // Reset in the middle of FORMAT
    bus.force_req = 1'b1;
    @(negedge clk);
    bus.force_req = 1'b0;
    cycles(7);
    rst = 1'b0;
    #1;
    check("mrst_strdata", bus.strdata, SPACES);
    check("mrst_cls", {255'd0, bus.cls}, 256'd0);
    check("mrst_busy", {255'd0, bus.busy}, 256'd0);
    @(negedge clk);
    c0 = cls_cnt;
    rst = 1'b1;
    wait_cls(40, n);
    check("mrst_latency", 256'(n), 256'd18);
    check("mrst_text", bus.strdata, line17("0BADF00D 00000000"));
    idle_wait();
    cycles(20);
    check("mrst_one_cls", 256'(cls_cnt - c0), 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
